// File: rtl/ram_pkg.sv
// Shared types and helpers for the byte-enable RAM with clear engine.
//   ram_state_t : clear-engine state (ST_CLEAR while zeroing, ST_IDLE otherwise)
//   WR / RD     : encodings of the wr_rd access-direction input
//   be_width()  : byte-enable width derived from the data width
package ram_pkg;

  typedef enum logic {ST_CLEAR, ST_IDLE} ram_state_t;

  localparam logic WR = 1'b1;
  localparam logic RD = 1'b0;

  function automatic int unsigned be_width(int unsigned data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/ram_rd_pipe.sv
// Read-data delay line: LAT register stages carrying data plus a valid bit.
// Ports:
//   clk      : clock
//   rst      : synchronous active-high flush (valid and data zeroed)
//   in_vld   : a read was accepted this cycle
//   in_data  : array word read this cycle
//   out_vld  : one-cycle strobe, LAT cycles after in_vld
//   out_data : read data; holds its last value while out_vld is low
module ram_rd_pipe #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned LAT    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_vld,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_vld,
  output logic [DATA_W-1:0] out_data
);

  logic [LAT-1:0]    vld_q;
  logic [DATA_W-1:0] data_q [LAT];

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      for (int i = 0; i < int'(LAT); i++) data_q[i] <= '0;
    end else begin
      vld_q[0] <= in_vld;
      if (in_vld) data_q[0] <= in_data;
      // Data only advances with a valid token so every stage holds its word.
      for (int i = 1; i < int'(LAT); i++) begin
        vld_q[i] <= vld_q[i-1];
        if (vld_q[i-1]) data_q[i] <= data_q[i-1];
      end
    end
  end

  assign out_vld  = vld_q[LAT-1];
  assign out_data = data_q[LAT-1];

endmodule

// File: rtl/ram_be_clr.sv
// Single-port synchronous RAM with per-byte write enables, 1- or 2-cycle read
// latency and a hardware clear engine that zeroes the array after reset or
// on a clr pulse.
// Ports:
//   clk      : clock, all logic on posedge
//   rst      : synchronous active-high reset; restarts the full clear
//   en       : access request
//   wr_rd    : 1 = write, 0 = read
//   addr     : word address
//   din      : write data
//   be       : byte-lane write enables, be[i] covers din[8i+7:8i]
//   clr      : one-cycle request to clear the array (ignored while busy)
//   dout     : read data, holds while dout_vld is low
//   dout_vld : one-cycle read-data strobe
//   busy     : clear engine running, accesses rejected
//   rej      : one-cycle strobe, an access was dropped because of busy
module ram_be_clr
  import ram_pkg::*;
#(
  parameter  int unsigned DATA_W = 32,
  parameter  int unsigned ADDR_W = 4,
  parameter  int unsigned RD_LAT = 1,
  localparam int unsigned BE_W   = be_width(DATA_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              wr_rd,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] din,
  input  logic [BE_W-1:0]   be,
  input  logic              clr,
  output logic [DATA_W-1:0] dout,
  output logic              dout_vld,
  output logic              busy,
  output logic              rej
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  if (DATA_W % 8 != 0) begin : g_bad_data_w
    $fatal(1, "ram_be_clr: DATA_W must be a multiple of 8");
  end
  if (RD_LAT != 1 && RD_LAT != 2) begin : g_bad_rd_lat
    $fatal(1, "ram_be_clr: RD_LAT must be 1 or 2");
  end

  ram_state_t        state_q, state_d;
  logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;
  logic              rej_q;
  logic              wr_fire, rd_fire;
  logic [DATA_W-1:0] mem [DEPTH];

  assign busy    = (state_q == ST_CLEAR);
  assign wr_fire = en && !busy && (wr_rd == WR);
  assign rd_fire = en && !busy && (wr_rd == RD);
  assign rej     = rej_q;

  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    unique case (state_q)
      ST_CLEAR: begin
        clr_ptr_d = clr_ptr_q + 1'b1;
        if (clr_ptr_q == ADDR_W'(DEPTH - 1)) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (clr) begin
          state_d   = ST_CLEAR;
          clr_ptr_d = '0;
        end
      end
      default: state_d = ST_CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_CLEAR;
      clr_ptr_q <= '0;
      rej_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
      rej_q     <= en && busy;
    end
  end

  // Array has no reset; it is zeroed by the clear engine once rst drops.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (busy) begin
        mem[clr_ptr_q] <= '0;
      end else if (wr_fire) begin
        for (int b = 0; b < int'(BE_W); b++) begin
          if (be[b]) mem[addr][8*b +: 8] <= din[8*b +: 8];
        end
      end
    end
  end

  ram_rd_pipe #(
    .DATA_W (DATA_W),
    .LAT    (RD_LAT)
  ) u_rd_pipe (
    .clk      (clk),
    .rst      (rst),
    .in_vld   (rd_fire),
    .in_data  (mem[addr]),
    .out_vld  (dout_vld),
    .out_data (dout)
  );

endmodule

// File: tb/tb_ram_be_clr.sv
// Directed bench for ram_be_clr: one RD_LAT=1 instance and one RD_LAT=2
// instance driven by the same stimulus.
module tb_ram_be_clr;

  logic        clk = 1'b0;
  logic        rst, en, wr_rd, clr;
  logic [3:0]  addr;
  logic [31:0] din;
  logic [3:0]  be;
  logic [31:0] dout, dout2;
  logic        dout_vld, busy, rej;
  logic        dout_vld2, busy2, rej2;

  int checks = 0;
  int errors = 0;
  int n;

  always #5 clk = ~clk;

  ram_be_clr #(.DATA_W(32), .ADDR_W(4), .RD_LAT(1)) dut (
    .clk(clk), .rst(rst), .en(en), .wr_rd(wr_rd), .addr(addr), .din(din), .be(be),
    .clr(clr), .dout(dout), .dout_vld(dout_vld), .busy(busy), .rej(rej)
  );

  ram_be_clr #(.DATA_W(32), .ADDR_W(4), .RD_LAT(2)) dut2 (
    .clk(clk), .rst(rst), .en(en), .wr_rd(wr_rd), .addr(addr), .din(din), .be(be),
    .clr(clr), .dout(dout2), .dout_vld(dout_vld2), .busy(busy2), .rej(rej2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] b);
    en = 1'b1; wr_rd = 1'b1; addr = a; din = d; be = b;
    tick();
    en = 1'b0;
  endtask

  task automatic rd(input logic [3:0] a);
    en = 1'b1; wr_rd = 1'b0; addr = a;
    tick();
    en = 1'b0;
  endtask

  // Counts busy cycles from now until busy falls, bounded at 40.
  task automatic count_busy(output int cnt, input int pulse_clr_at);
    cnt = 0;
    while (busy && cnt < 40) begin
      clr = (cnt == pulse_clr_at);
      cnt++;
      tick();
    end
    clr = 1'b0;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; wr_rd = 1'b0; clr = 1'b0; addr = '0; din = '0; be = '0;
    #1;

    // 1: reset, clear duration, all-zero readback
    repeat (5) tick();
    chk("rst_dout", dout, 32'h0);
    chk("rst_vld", {31'b0, dout_vld}, 32'h0);
    chk("rst_rej", {31'b0, rej}, 32'h0);
    chk("rst_busy", {31'b0, busy}, 32'h1);
    rst = 1'b0;
    count_busy(n, -1);
    chk("init_busy_cycles", n, 32'd16);
    chk("init_busy2", {31'b0, busy2}, 32'h0);
    for (int i = 0; i < 16; i++) begin
      en = 1'b1; wr_rd = 1'b0; addr = 4'(i);
      tick();
      chk("init_rd_vld", {31'b0, dout_vld}, 32'h1);
      chk("init_rd_data", dout, 32'h0);
    end
    en = 1'b0;
    tick();
    chk("init_rd_vld_end", {31'b0, dout_vld}, 32'h0);

    // 2: byte-lane merge
    wr(4'd3, 32'hDEADBEEF, 4'hF);
    chk("wr_no_vld", {31'b0, dout_vld}, 32'h0);
    wr(4'd3, 32'h000000AA, 4'b0001);
    rd(4'd3);
    chk("be_merge_vld", {31'b0, dout_vld}, 32'h1);
    chk("be_merge_data", dout, 32'hDEADBEAA);
    tick();
    chk("hold_vld", {31'b0, dout_vld}, 32'h0);
    chk("hold_data", dout, 32'hDEADBEAA);

    // 3: write then read on consecutive cycles, both latencies
    wr(4'd5, 32'h12345678, 4'hF);
    rd(4'd5);
    chk("wtr_vld", {31'b0, dout_vld}, 32'h1);
    chk("wtr_data", dout, 32'h12345678);
    chk("wtr_vld2_early", {31'b0, dout_vld2}, 32'h0);
    tick();
    chk("wtr_vld2", {31'b0, dout_vld2}, 32'h1);
    chk("wtr_data2", dout2, 32'h12345678);
    chk("wtr_vld_after", {31'b0, dout_vld}, 32'h0);
    tick();
    chk("wtr_vld2_after", {31'b0, dout_vld2}, 32'h0);

    // 4: fill, clr, rejected write, ignored second clr, zero readback
    for (int i = 0; i < 16; i++) wr(4'(i), 32'hFFFFFFFF, 4'hF);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("clr_busy", {31'b0, busy}, 32'h1);
    en = 1'b1; wr_rd = 1'b1; addr = 4'd2; din = 32'h12345678; be = 4'hF;
    tick();
    en = 1'b0;
    chk("busy_rej", {31'b0, rej}, 32'h1);
    chk("busy_rej2", {31'b0, rej2}, 32'h1);
    chk("busy_no_vld", {31'b0, dout_vld}, 32'h0);
    count_busy(n, 7);
    chk("clr_busy_cycles", n + 1, 32'd16);
    chk("rej_clears", {31'b0, rej}, 32'h0);
    chk("clr_keeps_dout", dout, 32'h12345678);
    for (int i = 0; i < 16; i++) begin
      rd(4'(i));
      chk("clr_rd_vld", {31'b0, dout_vld}, 32'h1);
      chk("clr_rd_data", dout, 32'h0);
    end

    // 5: rst in the middle of a clear restarts it from zero
    for (int i = 0; i < 16; i++) wr(4'(i), 32'hFFFFFFFF, 4'hF);
    rd(4'd0);
    chk("pre_rst_data", dout, 32'hFFFFFFFF);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    repeat (7) tick();
    rst = 1'b1;
    tick();
    chk("mid_rst_dout", dout, 32'h0);
    chk("mid_rst_vld", {31'b0, dout_vld}, 32'h0);
    chk("mid_rst_busy", {31'b0, busy}, 32'h1);
    rst = 1'b0;
    count_busy(n, -1);
    chk("mid_rst_busy_cycles", n, 32'd16);
    for (int i = 8; i < 16; i++) begin
      rd(4'(i));
      chk("mid_rst_rd_data", dout, 32'h0);
    end

    // 6: be=0 write is a no-op
    wr(4'd9, 32'hCAFEF00D, 4'h0);
    chk("be0_rej", {31'b0, rej}, 32'h0);
    rd(4'd9);
    chk("be0_vld", {31'b0, dout_vld}, 32'h1);
    chk("be0_data", dout, 32'h0);
    tick();
    chk("be0_data2", dout2, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
